// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-add multiplier controller.
// Drives an external ripple-carry adder with {hi, lo[0]?mcand:0} and
// shifts the (SIZE+1)-bit sum back into {hi, lo} once per cycle.
module shift_add_mul #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic [SIZE-1:0]   add_a,
  output logic [SIZE-1:0]   add_b,
  input  logic [SIZE:0]     add_result,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [SIZE-1:0] mcand;
  logic [SIZE-1:0] hi;
  logic [SIZE-1:0] lo;
  logic [CW-1:0]   count;

  logic [SIZE-1:0] hi_next;
  logic [SIZE-1:0] lo_next;
  logic [SIZE:0]   lo_ext;

  // Next {hi, lo}: one-bit right shift of {sum, lo}; built through a widened
  // vector so the SIZE=1 case needs no empty slice.
  always_comb begin
    lo_ext  = {add_result[0], lo};
    hi_next = add_result[SIZE:1];
    lo_next = lo_ext[SIZE:1];
  end

  // Adder operands and status flags follow the registers directly.
  always_comb begin
    add_a = hi;
    add_b = lo[0] ? mcand : '0;
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= multiplicand;
            hi    <= '0;
            lo    <= multiplier;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          hi    <= hi_next;
          lo    <= lo_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            product <= {hi_next, lo_next};
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed testbench for shift_add_mul (SIZE=8 main instance, SIZE=1 corner).
module tb_shift_add_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [8:0]  add_result;
  logic        busy;
  logic        done;
  logic [15:0] product;

  // SIZE=1 instance signals
  logic        s1_start;
  logic        s1_mcand;
  logic        s1_mplier;
  logic        s1_add_a;
  logic        s1_add_b;
  logic [1:0]  s1_add_result;
  logic        s1_busy;
  logic        s1_done;
  logic [1:0]  s1_product;

  int vectors;
  int miscompares;

  shift_add_mul #(.SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .busy(busy), .done(done), .product(product)
  );

  shift_add_mul #(.SIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start),
    .multiplicand(s1_mcand), .multiplier(s1_mplier),
    .add_a(s1_add_a), .add_b(s1_add_b), .add_result(s1_add_result),
    .busy(s1_busy), .done(s1_done), .product(s1_product)
  );

  // External adders, as the surrounding ALU would supply.
  assign add_result    = {1'b0, add_a} + {1'b0, add_b};
  assign s1_add_result = {1'b0, s1_add_a} + {1'b0, s1_add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for one cycle (no checking here).
  task automatic issue_start(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state busy=%b done=%b product=%h want 0/0/0000", busy, done, product);
    end
    vectors++;
    if (add_a !== 8'h00 || add_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_adder add_a=%h add_b=%h want 00/00", add_a, add_b);
    end
    rst_n = 1'b1;
  endtask

  // 13 x 11 = 143 with exact latency and product hold.
  task automatic test_basic;
    issue_start(8'd13, 8'd11);
    // issue_start already consumed the first busy cycle's negedge
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy c1 busy=%b done=%b want 1/0", busy, done);
    end
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_busy c%0d busy=%b done=%b want 1/0", i, busy, done);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== 16'h008F) begin
      miscompares++;
      $display("FAIL basic_done done=%b busy=%b product=%h want 1/0/008f", done, busy, product);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h008F) begin
      miscompares++;
      $display("FAIL basic_hold done=%b busy=%b product=%h want 0/0/008f", done, busy, product);
    end
  endtask

  // 255 x 255 exercises the adder carry.
  task automatic test_max;
    logic carry_seen;
    carry_seen = 1'b0;
    issue_start(8'd255, 8'd255);
    if (add_result[8]) carry_seen = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      if (add_result[8]) carry_seen = 1'b1;
    end
    vectors++;
    if (carry_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL max_carry seen=%b want 1", carry_seen);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || product !== 16'hFE01) begin
      miscompares++;
      $display("FAIL max_product done=%b product=%h want 1/fe01", done, product);
    end
  endtask

  // Zero operands keep the fixed latency.
  task automatic test_zero;
    logic [7:0] a_tab [2];
    logic [7:0] b_tab [2];
    a_tab[0] = 8'h00; b_tab[0] = 8'hA5;
    a_tab[1] = 8'hA5; b_tab[1] = 8'h00;
    for (int t = 0; t < 2; t++) begin
      issue_start(a_tab[t], b_tab[t]);
      for (int i = 2; i <= 8; i++) begin
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL zero%0d_busy c%0d busy=%b done=%b want 1/0", t, i, busy, done);
        end
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || product !== 16'h0000) begin
        miscompares++;
        $display("FAIL zero%0d_done done=%b product=%h want 1/0000", t, done, product);
      end
    end
  endtask

  // 7 x 9 with an ignored start at RUN cycle 4; operand sequence checked.
  task automatic test_ignore_start;
    logic [7:0] exp_a [8];
    logic [7:0] exp_b [8];
    exp_a[0] = 8'd0; exp_a[1] = 8'd3; exp_a[2] = 8'd1; exp_a[3] = 8'd0;
    exp_a[4] = 8'd3; exp_a[5] = 8'd1; exp_a[6] = 8'd0; exp_a[7] = 8'd0;
    exp_b[0] = 8'd7; exp_b[1] = 8'd0; exp_b[2] = 8'd0; exp_b[3] = 8'd7;
    exp_b[4] = 8'd0; exp_b[5] = 8'd0; exp_b[6] = 8'd0; exp_b[7] = 8'd0;
    issue_start(8'd7, 8'd9);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      start = 1'b0;
      if (i == 3) begin
        multiplicand = 8'd3;
        multiplier   = 8'd3;
        start        = 1'b1;
      end
      vectors++;
      if (add_a !== exp_a[i] || add_b !== exp_b[i]) begin
        miscompares++;
        $display("FAIL seq_7x9 c%0d add_a=%0d add_b=%0d want %0d/%0d", i + 1, add_a, add_b, exp_a[i], exp_b[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || product !== 16'd63) begin
      miscompares++;
      $display("FAIL ignore_start done=%b product=%0d want 1/63", done, product);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start_idle busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  // start held through DONE launches the next run directly.
  task automatic test_back_to_back;
    issue_start(8'd7, 8'd9);
    repeat (7) @(negedge clk);
    multiplicand = 8'd200;
    multiplier   = 8'd2;
    start        = 1'b1;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || product !== 16'd63) begin
      miscompares++;
      $display("FAIL b2b_first done=%b product=%0d want 1/63", done, product);
    end
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 16'd63) begin
      miscompares++;
      $display("FAIL b2b_restart busy=%b done=%b product=%0d want 1/0/63", busy, done, product);
    end
    repeat (7) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_last_busy busy=%b done=%b want 1/0", busy, done);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || product !== 16'h0190) begin
      miscompares++;
      $display("FAIL b2b_second done=%b product=%h want 1/0190", done, product);
    end
  endtask

  // Reset in RUN cycle 5 aborts the run; a fresh 6 x 7 then works.
  task automatic test_reset_mid_run;
    issue_start(8'd7, 8'd9);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      miscompares++;
      $display("FAIL midreset busy=%b done=%b product=%h want 0/0/0000", busy, done, product);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle busy=%b done=%b want 0/0", busy, done);
    end
    issue_start(8'd6, 8'd7);
    repeat (7) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_busy busy=%b done=%b want 1/0", busy, done);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || product !== 16'd42) begin
      miscompares++;
      $display("FAIL after_reset_done done=%b product=%0d want 1/42", done, product);
    end
  endtask

  // SIZE=1 corner: single RUN cycle, product = {0, a&b}.
  task automatic test_size1;
    logic       a_tab [3];
    logic       b_tab [3];
    logic [1:0] p_tab [3];
    a_tab[0] = 1'b1; b_tab[0] = 1'b1; p_tab[0] = 2'b01;
    a_tab[1] = 1'b1; b_tab[1] = 1'b0; p_tab[1] = 2'b00;
    a_tab[2] = 1'b0; b_tab[2] = 1'b1; p_tab[2] = 2'b00;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      s1_mcand  = a_tab[t];
      s1_mplier = b_tab[t];
      s1_start  = 1'b1;
      @(negedge clk);
      s1_start  = 1'b0;
      vectors++;
      if (s1_busy !== 1'b1 || s1_done !== 1'b0) begin
        miscompares++;
        $display("FAIL size1_busy t%0d busy=%b done=%b want 1/0", t, s1_busy, s1_done);
      end
      @(negedge clk);
      vectors++;
      if (s1_done !== 1'b1 || s1_product !== p_tab[t]) begin
        miscompares++;
        $display("FAIL size1_done t%0d done=%b product=%b want 1/%b", t, s1_done, s1_product, p_tab[t]);
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    s1_start     = 1'b0;
    s1_mcand     = 1'b0;
    s1_mplier    = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_size1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
